// File: rtl/sm_cfg_pkg.sv
// Shared definitions for the switch-matrix configuration loader:
// side codes, frame defaults, FSM states and the wire-number-to-(side, index) map.
package sm_cfg_pkg;

  localparam logic [2:0] SIDE_NONE   = 3'd0;
  localparam logic [2:0] SIDE_TOP    = 3'd1;
  localparam logic [2:0] SIDE_RIGHT  = 3'd2;
  localparam logic [2:0] SIDE_BOTTOM = 3'd3;
  localparam logic [2:0] SIDE_LEFT   = 3'd4;

  localparam int         CFG_W    = 6;
  localparam logic [7:0] CFG_SYNC = 8'hA5;

  typedef enum logic [1:0] {
    HUNT,
    PAYLOAD,
    CHECK
  } state_e;

  typedef struct packed {
    logic [2:0] side;
    logic [2:0] idx;
  } wire_t;

  // Word k order: top[0..n_tb-1], bottom[..], left[0..n_lr-1], right[..]
  function automatic wire_t wire_of(input int k, input int n_tb, input int n_lr);
    wire_t w;
    if (k < n_tb) begin
      w.side = SIDE_TOP;
      w.idx  = 3'(k);
    end else if (k < 2*n_tb) begin
      w.side = SIDE_BOTTOM;
      w.idx  = 3'(k - n_tb);
    end else if (k < 2*n_tb + n_lr) begin
      w.side = SIDE_LEFT;
      w.idx  = 3'(k - 2*n_tb);
    end else begin
      w.side = SIDE_RIGHT;
      w.idx  = 3'(k - 2*n_tb - n_lr);
    end
    return w;
  endfunction

endpackage

// File: rtl/sm_cfg_loader_if.sv
// Serial configuration port plus the committed route bus and status strobes.
// master = chip-level configuration source, slave = the loader.
interface sm_cfg_loader_if #(
  parameter int BUS_W = 108
);
  logic             cfg_valid;
  logic             cfg_bit;
  logic             cfg_abort;
  logic [BUS_W-1:0] cfg_bus;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output cfg_valid, cfg_bit, cfg_abort,
    input  cfg_bus, busy, done, err
  );

  modport slave (
    input  cfg_valid, cfg_bit, cfg_abort,
    output cfg_bus, busy, done, err
  );
endinterface

// File: rtl/sm_cfg_word_check.sv
// Flags a route word that cannot be legal for tile wire k: bad side code,
// out-of-range source index, or a wire routed back onto itself.
module sm_cfg_word_check
  import sm_cfg_pkg::*;
#(
  parameter int N_TB = 5,
  parameter int N_LR = 4,
  parameter int W    = CFG_W,
  parameter int KW   = 5
) (
  input  logic [W-1:0]  word_i,
  input  logic [KW-1:0] k_i,
  output logic          illegal_o
);

  logic [2:0]   side;
  logic [W-4:0] idx;
  wire_t        self_w;

  assign side   = word_i[2:0];
  assign idx    = word_i[W-1:3];
  assign self_w = wire_of(int'(k_i), N_TB, N_LR);

  always_comb begin
    illegal_o = 1'b0;
    case (side)
      SIDE_NONE:               illegal_o = 1'b0;
      SIDE_TOP, SIDE_BOTTOM:   illegal_o = (int'(idx) >= N_TB);
      SIDE_RIGHT, SIDE_LEFT:   illegal_o = (int'(idx) >= N_LR);
      default:                 illegal_o = 1'b1;
    endcase
    // An unconnected word never counts as a self-loop; its index is don't-care
    if (side != SIDE_NONE && side == self_w.side && int'(idx) == int'(self_w.idx))
      illegal_o = 1'b1;
  end

endmodule

// File: rtl/sm_cfg_loader.sv
// Serial route-word loader: hunts for sync, shifts in one word per tile wire,
// validates words and checksum, then commits the whole frame atomically.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   HUNT    | shift valid bits through sync detector, wait for SYNC
//   PAYLOAD | shift N_WORDS route words into shadow, fold checksum/bad
//   CHECK   | shift checksum; commit on match and no bad word, else err
module sm_cfg_loader
  import sm_cfg_pkg::*;
#(
  parameter int         N_TB = 5,
  parameter int         N_LR = 4,
  parameter int         W    = CFG_W,
  parameter logic [7:0] SYNC = CFG_SYNC
) (
  input logic            clk,
  input logic            rst_n,
  sm_cfg_loader_if.slave cfg_if
);

  localparam int N_WORDS = 2*N_TB + 2*N_LR;
  localparam int KW      = $clog2(N_WORDS);
  localparam int BW      = $clog2(W);
  localparam int BUS_W   = N_WORDS * W;

  localparam logic [BW-1:0] LAST_BIT  = BW'(W - 1);
  localparam logic [KW-1:0] LAST_WORD = KW'(N_WORDS - 1);

  state_e           state_q;
  logic [6:0]       sync_q;
  logic [BW-1:0]    bit_cnt_q;
  logic [KW-1:0]    word_cnt_q;
  logic [BUS_W-1:0] shadow_q;
  logic [BUS_W-1:0] bus_q;
  logic [W-1:0]     acc_q;
  logic [W-1:0]     chk_q;
  logic             bad_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic [7:0]       sync_d;
  logic [W-1:0]     cur_word;
  logic [W-1:0]     word_d;
  logic [W-1:0]     chk_d;
  logic             word_bad;

  // Only seven history bits need storage; the eighth is the incoming bit
  assign sync_d = {sync_q, cfg_if.cfg_bit};

  // Bits land at their final position, so a word is complete on its last bit
  always_comb begin
    cur_word = shadow_q[int'(word_cnt_q)*W +: W];
    word_d   = cur_word;
    word_d[LAST_BIT - bit_cnt_q] = cfg_if.cfg_bit;
    chk_d    = chk_q;
    chk_d[LAST_BIT - bit_cnt_q]  = cfg_if.cfg_bit;
  end

  sm_cfg_word_check #(
    .N_TB (N_TB),
    .N_LR (N_LR),
    .W    (W),
    .KW   (KW)
  ) u_word_check (
    .word_i    (word_d),
    .k_i       (word_cnt_q),
    .illegal_o (word_bad)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      sync_q     <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      shadow_q   <= '0;
      bus_q      <= '0;
      acc_q      <= '0;
      chk_q      <= '0;
      bad_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (cfg_if.cfg_abort) begin
        state_q <= HUNT;
        sync_q  <= '0;
        busy_q  <= 1'b0;
      end else if (cfg_if.cfg_valid) begin
        case (state_q)
          HUNT: begin
            sync_q <= sync_d[6:0];
            if (sync_d == SYNC) begin
              state_q    <= PAYLOAD;
              busy_q     <= 1'b1;
              bit_cnt_q  <= '0;
              word_cnt_q <= '0;
              acc_q      <= '0;
              bad_q      <= 1'b0;
            end
          end
          PAYLOAD: begin
            shadow_q[int'(word_cnt_q)*W +: W] <= word_d;
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q <= '0;
              acc_q     <= acc_q ^ word_d;
              bad_q     <= bad_q | word_bad;
              if (word_cnt_q == LAST_WORD) state_q <= CHECK;
              else word_cnt_q <= word_cnt_q + 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
          CHECK: begin
            chk_q <= chk_d;
            if (bit_cnt_q == LAST_BIT) begin
              state_q   <= HUNT;
              sync_q    <= '0;
              busy_q    <= 1'b0;
              bit_cnt_q <= '0;
              if (chk_d == acc_q && !bad_q) begin
                bus_q  <= shadow_q;
                done_q <= 1'b1;
              end else begin
                err_q  <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= HUNT;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cfg_if.cfg_bus = bus_q;
  assign cfg_if.busy    = busy_q;
  assign cfg_if.done    = done_q;
  assign cfg_if.err     = err_q;

endmodule

// File: tb/tb_sm_cfg_loader.sv
// Bench for sm_cfg_loader: directed frames plus random frames scored against
// a frame-level model (XOR checksum, per-word legality, atomic commit).
module tb_sm_cfg_loader;
  import sm_cfg_pkg::*;

  localparam int N_TB  = 5;
  localparam int N_LR  = 4;
  localparam int W     = 6;
  localparam int NW    = 2*N_TB + 2*N_LR;
  localparam int BUS_W = NW * W;

  typedef logic [W-1:0] frame_t [NW];

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  sm_cfg_loader_if #(.BUS_W(BUS_W)) ifc ();

  sm_cfg_loader #(
    .N_TB (N_TB),
    .N_LR (N_LR),
    .W    (W),
    .SYNC (8'hA5)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cfg_if (ifc)
  );

  always #5 clk = ~clk;

  int               total = 0;
  int               bad   = 0;
  logic [BUS_W-1:0] exp_bus;
  logic [7:0]       sync_pat = 8'hA5;

  task automatic check_eq(input string tag, input logic [BUS_W-1:0] got,
                          input logic [BUS_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit word_ok(input logic [W-1:0] w, input int k);
    int    side;
    int    idx;
    wire_t me;
    side = int'(w[2:0]);
    idx  = int'(w[5:3]);
    me   = wire_of(k, N_TB, N_LR);
    if (side == 0) return 1'b1;
    if (side > 4) return 1'b0;
    if ((side == 1 || side == 3) && idx >= N_TB) return 1'b0;
    if ((side == 2 || side == 4) && idx >= N_LR) return 1'b0;
    if (side == int'(me.side) && idx == int'(me.idx)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [W-1:0] xor_of(input frame_t f);
    logic [W-1:0] x = '0;
    for (int k = 0; k < NW; k++) x ^= f[k];
    return x;
  endfunction

  function automatic logic [BUS_W-1:0] pack(input frame_t f);
    logic [BUS_W-1:0] b = '0;
    for (int k = 0; k < NW; k++) b[k*W +: W] = f[k];
    return b;
  endfunction

  task automatic send_bit(input logic b, input int gap);
    ifc.cfg_valid = 1'b1;
    ifc.cfg_bit   = b;
    @(posedge clk); #1;
    ifc.cfg_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] v, input int max_gap);
    for (int i = 7; i >= 0; i--) send_bit(v[i], $urandom_range(0, max_gap));
  endtask

  task automatic send_sync(input string tag, input int max_gap);
    for (int i = 7; i >= 1; i--) send_bit(sync_pat[i], $urandom_range(0, max_gap));
    send_bit(sync_pat[0], 0);
    check_eq({tag, ".busy_on"}, BUS_W'(ifc.busy), BUS_W'(1));
  endtask

  task automatic send_words(input frame_t f, input int n, input int max_gap);
    for (int k = 0; k < n; k++)
      for (int i = W-1; i >= 0; i--) send_bit(f[k][i], $urandom_range(0, max_gap));
  endtask

  task automatic run_frame(input string tag, input frame_t f,
                           input logic [W-1:0] csum, input int max_gap);
    bit ok;
    send_sync(tag, max_gap);
    send_words(f, NW, max_gap);
    for (int i = W-1; i >= 1; i--) send_bit(csum[i], $urandom_range(0, max_gap));
    send_bit(csum[0], 0);
    ok = (csum == xor_of(f));
    for (int k = 0; k < NW; k++) if (!word_ok(f[k], k)) ok = 1'b0;
    if (ok) exp_bus = pack(f);
    check_eq({tag, ".done"}, BUS_W'(ifc.done), BUS_W'(ok));
    check_eq({tag, ".err"},  BUS_W'(ifc.err),  BUS_W'(!ok));
    check_eq({tag, ".bus"},  ifc.cfg_bus, exp_bus);
    check_eq({tag, ".busy_off"}, BUS_W'(ifc.busy), BUS_W'(0));
  endtask

  frame_t fa, fb, fx;

  initial begin
    ifc.cfg_valid = 1'b0;
    ifc.cfg_bit   = 1'b0;
    ifc.cfg_abort = 1'b0;
    exp_bus       = '0;

    #12;
    check_eq("rst.bus",  ifc.cfg_bus, '0);
    check_eq("rst.busy", BUS_W'(ifc.busy), '0);
    check_eq("rst.done", BUS_W'(ifc.done), '0);
    check_eq("rst.err",  BUS_W'(ifc.err),  '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < NW; k++) fa[k] = '0;
    fa[0]  = 6'b010100;
    fa[17] = 6'b001001;

    run_frame("badcsum", fa, 6'b000000, 0);

    fx = fa; fx[10] = 6'b100100;
    run_frame("ill_idx", fx, xor_of(fx), 0);
    fx = fa; fx[3] = 6'b011001;
    run_frame("ill_self", fx, xor_of(fx), 0);
    fx = fa; fx[2] = 6'b000110;
    run_frame("ill_side", fx, xor_of(fx), 0);

    run_frame("good", fa, 6'b011101, 0);
    check_eq("good.lo", BUS_W'(ifc.cfg_bus[5:0]), BUS_W'(6'b010100));
    check_eq("good.hi", BUS_W'(ifc.cfg_bus[107:102]), BUS_W'(6'b001001));

    for (int k = 0; k < NW; k++) fb[k] = '0;
    fb[5]  = 6'b011100;
    fb[14] = 6'b000001;
    fb[9]  = 6'b111000;
    run_frame("b2b_a", fa, xor_of(fa), 0);
    run_frame("b2b_b", fb, xor_of(fb), 0);

    send_byte(8'h5A, 7);
    send_byte(8'hF0, 7);
    run_frame("gaps", fa, xor_of(fa), 7);

    send_sync("abort", 0);
    send_words(fb, 9, 1);
    for (int i = W-1; i >= W-3; i--) send_bit(fb[9][i], 0);
    ifc.cfg_abort = 1'b1;
    ifc.cfg_valid = 1'b1;
    ifc.cfg_bit   = 1'b1;
    @(posedge clk); #1;
    ifc.cfg_abort = 1'b0;
    ifc.cfg_valid = 1'b0;
    check_eq("abort.busy", BUS_W'(ifc.busy), '0);
    check_eq("abort.done", BUS_W'(ifc.done), '0);
    check_eq("abort.err",  BUS_W'(ifc.err),  '0);
    check_eq("abort.bus",  ifc.cfg_bus, exp_bus);
    run_frame("after_abort", fb, xor_of(fb), 0);

    send_sync("reset", 0);
    send_words(fa, 12, 0);
    rst_n = 1'b0;
    #1;
    exp_bus = '0;
    check_eq("reset.bus",  ifc.cfg_bus, exp_bus);
    check_eq("reset.busy", BUS_W'(ifc.busy), '0);
    #3; rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame("after_reset", fa, xor_of(fa), 0);

    for (int n = 0; n < 20; n++) begin
      logic [W-1:0] cs;
      for (int k = 0; k < NW; k++) begin
        fx[k] = '0;
        for (int t = 0; t < 200; t++) begin
          logic [W-1:0] w;
          w = W'($urandom_range(0, 63));
          if (word_ok(w, k)) begin fx[k] = w; break; end
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        int    kk;
        wire_t me;
        kk = $urandom_range(0, NW-1);
        me = wire_of(kk, N_TB, N_LR);
        if ($urandom_range(0, 1) == 0) fx[kk] = {me.idx, me.side};
        else fx[kk] = {3'($urandom_range(0, 7)), 3'($urandom_range(5, 7))};
      end
      cs = xor_of(fx);
      if ($urandom_range(0, 3) == 0) cs = cs ^ W'($urandom_range(1, 63));
      run_frame($sformatf("rand%0d", n), fx, cs, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
